crack: RTL and testbench
========================

# crack

Brute-force key search controller that sits directly downstream of `arc4`. It steps a 24-bit candidate key through a range and pulses `arc4` to decrypt the ciphertext with each candidate. After each decryption it scans the length-prefixed plaintext memory that `arc4` wrote and stops at the first key whose plaintext is entirely printable ASCII. It reports that key, or reports that no key in the range qualified.

## Interface
Parameters:
- `KEY_FIRST`, default 24'h000000: first candidate key.
- `KEY_LAST`, default 24'hFFFFFF: last candidate key, inclusive. `KEY_LAST` ≥ `KEY_FIRST`.

Ports:
- `clk` in 1: single clock; all state updates on rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `en` in 1: one-cycle start pulse; honoured only while `rdy`=1.
- `rdy` out 1: high when idle and able to accept `en`.
- `key` out 24: result key; valid when `rdy`=1 and `key_valid`=1.
- `key_valid` out 1: 1 means the last search found a key; 0 means the range was exhausted or no search has run.
- `a4_en` out 1: one-cycle start pulse to `arc4`.
- `a4_rdy` in 1: `arc4` ready.
- `a4_key` out 24: candidate key to `arc4`; held stable for the whole decryption.
- `chk_addr` out 8: read address, second port of the plaintext memory.
- `chk_rddata` in 8: read data; synchronous, 1-cycle latency.

## Operation
- Plaintext format: `pt[0]` is length L (0–255); `pt[1..L]` are message bytes.
- A byte is printable iff it is in 0x20..0x7E inclusive.
- States:
  - IDLE: `rdy`=1. On `en`, load `a4_key`=`KEY_FIRST`, clear `key_valid`, go to START.
  - START: `a4_en`=1 for exactly this cycle, but only if `a4_rdy`=1; otherwise wait here with `a4_en`=0. Then go to WAIT_BUSY.
  - WAIT_BUSY: wait for `a4_rdy`=0, then go to WAIT_DONE.
  - WAIT_DONE: wait for `a4_rdy`=1. Drive `chk_addr`=0, go to RD_LEN.
  - RD_LEN: capture L from `chk_rddata` one cycle after the address.
    - L=0: go to FOUND.
    - Else: `chk_addr`=1, index i=1, go to SCAN.
  - SCAN: one cycle after each address, test the byte at `pt[i]`.
    - Non-printable: go to NEXT.
    - Printable and i=L: go to FOUND.
    - Otherwise: i+1, `chk_addr`=i+1. Addresses are pipelined, so one byte is tested per cycle after the first.
  - NEXT:
    - `a4_key`=`KEY_LAST`: `key_valid`=0, go to IDLE.
    - Else: `a4_key`+1, go to START.
  - FOUND: `key`←`a4_key`, `key_valid`=1, go to IDLE.
- Index i is 9 bits internally, so L=255 does not wrap. `chk_addr` is the low 8 bits of i.
- `a4_key` increments without wrap; termination is by the `KEY_LAST` compare.
- `en` while `rdy`=0 is ignored.
- A new `en` after completion restarts from `KEY_FIRST`. `key` and `key_valid` hold until `en` is accepted, at which point `key_valid` clears.

## Timing
- Reset values: `rdy`=1, `key`=0, `key_valid`=0, `a4_en`=0, `a4_key`=0, `chk_addr`=0, state IDLE.
- Reset asserted mid-search aborts immediately to reset values, with no further `a4_en` pulse.
- `rdy` falls the cycle after `en` is sampled. It rises in the same cycle `key`/`key_valid` become final.
- `a4_en` is never asserted for more than one consecutive cycle.
- Scan latency per candidate is L+2 cycles after `arc4` completes; rejection latency is j+2 cycles for a first bad byte at index j.
- `a4_key` changes only in IDLE→START and NEXT.

## Structure
- Shared package `crack_pkg`:
  - state enum `crack_state_t`;
  - constants `PRINT_LO`=8'h20, `PRINT_HI`=8'h7E;
  - typedef `key_t` = logic [23:0].
- One sub-module is natural: `printable_chk`, a combinational byte → 1-bit printable test.
- `crack` itself is a single FSM plus key and index registers.
- The top level instantiates `crack`, `arc4`, and the dual-port plaintext memory. It is outside this block.

## Test plan
- Bench uses a behavioural `arc4` model:
  - `rdy` drops 1 cycle after `en`;
  - rises 20 cycles later;
  - writes a programmable `pt` image per key into a 1-cycle-latency memory.
- Scenario 1: `KEY_FIRST`=0, `KEY_LAST`=15. Model yields printable "HI" (L=2) only for key 24'h00000B. Expected: `key`=24'h00000B, `key_valid`=1, exactly 12 `a4_en` pulses.
- Scenario 2: same range, every key yields a 0x07 byte at index 1. Expected: `key_valid`=0, `rdy`=1, 16 `a4_en` pulses, `a4_key` ends at 24'h00000F.
- Scenario 3: key 0 yields L=0. Expected: `key`=0, `key_valid`=1 after one decryption.
- Scenario 4: key 3 yields L=255, all bytes 0x7E; boundary bytes 0x1F/0x7F appear at index 255 for keys 1/2. Expected: `key`=3; the scan reads address 255 and never reads address 0 after the length read.
- Scenario 5: pulse `en` during the search, and deassert `rst_n` during key 5's scan.
  - Expected: extra `en` ignored.
  - On reset: all outputs at reset values within the same cycle, and no `a4_en` pulse until a new `en`.
- Scenario 6: hold `a4_rdy`=0 for 10 cycles before the first START. Expected: `a4_en` is delayed until `a4_rdy`=1, then a single pulse.

Source files
------------

// File: rtl/crack_pkg.sv
// Shared types and constants for the crack key-search controller.
package crack_pkg;

  localparam int unsigned KEY_W  = 24;
  localparam int unsigned ADDR_W = 8;
  localparam int unsigned DATA_W = 8;
  localparam int unsigned IDX_W  = 9;

  localparam logic [DATA_W-1:0] PRINT_LO = 8'h20;
  localparam logic [DATA_W-1:0] PRINT_HI = 8'h7E;

  typedef logic [KEY_W-1:0] key_t;

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_WAIT_BUSY,
    S_WAIT_DONE,
    S_RD_LEN,
    S_SCAN,
    S_NEXT,
    S_FOUND
  } crack_state_t;

endpackage

// File: rtl/crack_printable_chk.sv
// Combinational test: is a plaintext byte printable ASCII (0x20..0x7E)?
module printable_chk
  import crack_pkg::*;
(
  input  logic [DATA_W-1:0] data,
  output logic              printable_c
);

  assign printable_c = (data >= PRINT_LO) && (data <= PRINT_HI);

endmodule

// File: rtl/crack.sv
// Brute-force key search: drives arc4 per candidate key, then scans the
// length-prefixed plaintext for an all-printable message.
module crack
  import crack_pkg::*;
#(
  parameter key_t KEY_FIRST = 24'h000000,
  parameter key_t KEY_LAST  = 24'hFFFFFF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  output logic              rdy,
  output logic [KEY_W-1:0]  key,
  output logic              key_valid,
  output logic              a4_en,
  input  logic              a4_rdy,
  output logic [KEY_W-1:0]  a4_key,
  output logic [ADDR_W-1:0] chk_addr,
  input  logic [DATA_W-1:0] chk_rddata
);

  crack_state_t      state_q, state_d;
  logic              rdy_q, rdy_d;
  key_t              key_q, key_d;
  logic              key_valid_q, key_valid_d;
  logic              a4_en_q, a4_en_d;
  key_t              a4_key_q, a4_key_d;
  logic [ADDR_W-1:0] chk_addr_q, chk_addr_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [IDX_W-1:0]  len_q, len_d;
  logic [IDX_W-1:0]  idx_ahead;
  logic              byte_ok_c;

  printable_chk u_printable_chk (
    .data        (chk_rddata),
    .printable_c (byte_ok_c)
  );

  // Address runs one byte ahead of the index so one byte is tested per cycle.
  assign idx_ahead = idx_q + IDX_W'(2);

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      rdy_q       <= 1'b1;
      key_q       <= '0;
      key_valid_q <= 1'b0;
      a4_en_q     <= 1'b0;
      a4_key_q    <= '0;
      chk_addr_q  <= '0;
      idx_q       <= '0;
      len_q       <= '0;
    end else begin
      state_q     <= state_d;
      rdy_q       <= rdy_d;
      key_q       <= key_d;
      key_valid_q <= key_valid_d;
      a4_en_q     <= a4_en_d;
      a4_key_q    <= a4_key_d;
      chk_addr_q  <= chk_addr_d;
      idx_q       <= idx_d;
      len_q       <= len_d;
    end
  end

  // Next-state and next-output logic.
  always_comb begin
    state_d     = state_q;
    rdy_d       = rdy_q;
    key_d       = key_q;
    key_valid_d = key_valid_q;
    a4_en_d     = 1'b0;
    a4_key_d    = a4_key_q;
    chk_addr_d  = chk_addr_q;
    idx_d       = idx_q;
    len_d       = len_q;

    case (state_q)
      S_IDLE: begin
        if (en) begin
          a4_key_d    = KEY_FIRST;
          key_valid_d = 1'b0;
          rdy_d       = 1'b0;
          state_d     = S_START;
        end
      end
      S_START: begin
        chk_addr_d = '0;
        if (a4_rdy) begin
          a4_en_d = 1'b1;
          state_d = S_WAIT_BUSY;
        end
      end
      S_WAIT_BUSY: begin
        chk_addr_d = '0;
        if (!a4_rdy) begin
          state_d = S_WAIT_DONE;
        end
      end
      S_WAIT_DONE: begin
        // Length address is already on the bus; prefetch byte 1 on exit.
        chk_addr_d = '0;
        if (a4_rdy) begin
          chk_addr_d = ADDR_W'(1);
          state_d    = S_RD_LEN;
        end
      end
      S_RD_LEN: begin
        len_d = IDX_W'(chk_rddata);
        if (chk_rddata == '0) begin
          state_d = S_FOUND;
        end else begin
          idx_d = IDX_W'(1);
          if (chk_rddata >= DATA_W'(2)) begin
            chk_addr_d = ADDR_W'(2);
          end
          state_d = S_SCAN;
        end
      end
      S_SCAN: begin
        if (!byte_ok_c) begin
          state_d = S_NEXT;
        end else if (idx_q == len_q) begin
          state_d = S_FOUND;
        end else begin
          idx_d = idx_q + IDX_W'(1);
          // Never prefetch past the message end, so address 0 is not revisited.
          if (idx_ahead <= len_q) begin
            chk_addr_d = ADDR_W'(idx_ahead);
          end
        end
      end
      S_NEXT: begin
        if (a4_key_q == KEY_LAST) begin
          key_valid_d = 1'b0;
          rdy_d       = 1'b1;
          state_d     = S_IDLE;
        end else begin
          a4_key_d = a4_key_q + KEY_W'(1);
          state_d  = S_START;
        end
      end
      S_FOUND: begin
        key_d       = a4_key_q;
        key_valid_d = 1'b1;
        rdy_d       = 1'b1;
        state_d     = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign rdy       = rdy_q;
  assign key       = key_q;
  assign key_valid = key_valid_q;
  assign a4_en     = a4_en_q;
  assign a4_key    = a4_key_q;
  assign chk_addr  = chk_addr_q;

endmodule

// File: tb/tb_crack.sv
// Directed bench for crack with a behavioural arc4 model and plaintext memory.
module tb_crack;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        en = 1'b0;
  logic        rdy;
  logic [23:0] key;
  logic        key_valid;
  logic        a4_en;
  logic        a4_rdy;
  logic [23:0] a4_key;
  logic [7:0]  chk_addr;
  logic [7:0]  chk_rddata;

  int          tests = 0;
  int          fails = 0;
  int          scen = 0;
  int          pulses = 0;
  int          base = 0;
  logic        dbl = 1'b0;
  logic        prev_en = 1'b0;
  logic        hold_busy = 1'b0;

  logic        model_rdy = 1'b1;
  int          busy_cnt = 0;
  logic [23:0] cur_key = '0;
  logic [7:0]  mem [256];
  logic        armed = 1'b0;
  logic        saw_nz = 1'b0;
  logic        seen255 = 1'b0;
  logic        zero_after = 1'b0;

  crack #(.KEY_FIRST(24'h000000), .KEY_LAST(24'h00000F)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .en         (en),
    .rdy        (rdy),
    .key        (key),
    .key_valid  (key_valid),
    .a4_en      (a4_en),
    .a4_rdy     (a4_rdy),
    .a4_key     (a4_key),
    .chk_addr   (chk_addr),
    .chk_rddata (chk_rddata)
  );

  always #5 clk = ~clk;

  assign a4_rdy = model_rdy & ~hold_busy;

  // Plaintext image produced by the arc4 model for each scenario and key.
  function automatic logic [7:0] img_byte(input int s, input logic [23:0] k, input int idx);
    logic [7:0] b;
    b = 8'h00;
    case (s)
      1: begin
        if (idx == 0) b = 8'd2;
        else if (idx == 1) b = 8'h48;
        else if (idx == 2) b = (k == 24'h00000B) ? 8'h49 : 8'h80;
      end
      2: begin
        if (idx == 0) b = 8'd3;
        else if (idx == 1) b = 8'h07;
        else b = 8'h41;
      end
      3, 6: begin
        if (k != 24'h0) b = (idx == 0) ? 8'd1 : 8'h00;
      end
      4: begin
        if (k == 24'h0) b = (idx == 0) ? 8'd1 : 8'h00;
        else if (idx == 0) b = 8'd255;
        else if (idx == 255) b = (k == 24'h1) ? 8'h1F : (k == 24'h2) ? 8'h7F : 8'h7E;
        else b = 8'h7E;
      end
      5: begin
        if (k == 24'h5) b = (idx == 0) ? 8'd200 : 8'h41;
        else b = (idx == 0) ? 8'd1 : 8'h07;
      end
      default: b = 8'h00;
    endcase
    return b;
  endfunction

  // Behavioural arc4 and 1-cycle-latency plaintext memory.
  always @(posedge clk) begin
    if (a4_en && model_rdy) begin
      cur_key   <= a4_key;
      model_rdy <= 1'b0;
      busy_cnt  <= 20;
      for (int k = 0; k < 256; k++) mem[k] <= img_byte(scen, a4_key, k);
    end else if (!model_rdy) begin
      if (busy_cnt == 1) begin
        model_rdy <= 1'b1;
        if (scen == 4 && cur_key == 24'h3) armed <= 1'b1;
      end
      busy_cnt <= busy_cnt - 1;
    end
    chk_rddata <= mem[chk_addr];
  end

  // Pulse counting and back-to-back a4_en detection.
  always @(posedge clk) begin
    if (a4_en) pulses <= pulses + 1;
    if (a4_en && prev_en) dbl <= 1'b1;
    prev_en <= a4_en;
  end

  // Address trace for the L=255 winning candidate.
  always @(negedge clk) begin
    if (scen == 4 && armed && !rdy) begin
      if (chk_addr != 8'd0) saw_nz <= 1'b1;
      if (chk_addr == 8'd255) seen255 <= 1'b1;
      if (saw_nz && chk_addr == 8'd0) zero_after <= 1'b1;
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic pulse_en();
    @(negedge clk) en = 1'b1;
    @(negedge clk) en = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    for (int c = 0; c < budget && !rdy; c++) @(negedge clk);
    check("done_timeout", 32'(rdy), 32'd1);
  endtask

  initial begin
    for (int k = 0; k < 256; k++) mem[k] = 8'h00;
    repeat (2) @(negedge clk);
    check("rst_rdy", 32'(rdy), 32'd1);
    check("rst_key", 32'(key), 32'd0);
    check("rst_key_valid", 32'(key_valid), 32'd0);
    check("rst_a4_en", 32'(a4_en), 32'd0);
    check("rst_a4_key", 32'(a4_key), 32'd0);
    check("rst_chk_addr", 32'(chk_addr), 32'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Scenario 1: only key 0xB decrypts to "HI".
    scen = 1;
    base = pulses;
    pulse_en();
    check("s1_rdy_fall", 32'(rdy), 32'd0);
    wait_done(3000);
    check("s1_key", 32'(key), 32'h00000B);
    check("s1_key_valid", 32'(key_valid), 32'd1);
    check("s1_pulses", 32'(pulses - base), 32'd12);
    repeat (5) @(negedge clk);
    check("s1_key_hold", 32'(key), 32'h00000B);
    check("s1_valid_hold", 32'(key_valid), 32'd1);

    // Scenario 2: every key rejected at index 1.
    scen = 2;
    base = pulses;
    pulse_en();
    check("s2_valid_clear", 32'(key_valid), 32'd0);
    wait_done(3000);
    check("s2_key_valid", 32'(key_valid), 32'd0);
    check("s2_rdy", 32'(rdy), 32'd1);
    check("s2_pulses", 32'(pulses - base), 32'd16);
    check("s2_a4_key", 32'(a4_key), 32'h00000F);

    // Scenario 3: empty message for key 0 is accepted.
    scen = 3;
    base = pulses;
    pulse_en();
    wait_done(500);
    check("s3_key", 32'(key), 32'd0);
    check("s3_key_valid", 32'(key_valid), 32'd1);
    check("s3_pulses", 32'(pulses - base), 32'd1);

    // Scenario 4: L=255 messages with boundary bytes at the last index.
    scen = 4;
    base = pulses;
    pulse_en();
    wait_done(3000);
    check("s4_key", 32'(key), 32'h000003);
    check("s4_key_valid", 32'(key_valid), 32'd1);
    check("s4_pulses", 32'(pulses - base), 32'd4);
    check("s4_read_255", 32'(seen255), 32'd1);
    check("s4_no_addr0", 32'(zero_after), 32'd0);

    // Scenario 5: extra en ignored, then reset during key 5's scan.
    scen = 5;
    pulse_en();
    for (int c = 0; c < 1000 && a4_key != 24'h2; c++) @(negedge clk);
    check("s5_reach_key2", 32'(a4_key), 32'h2);
    pulse_en();
    repeat (30) @(negedge clk);
    check("s5_en_ignored_rdy", 32'(rdy), 32'd0);
    check("s5_en_ignored_key", 32'(a4_key >= 24'h2), 32'd1);
    for (int c = 0; c < 1000 && a4_key != 24'h5; c++) @(negedge clk);
    check("s5_reach_key5", 32'(a4_key), 32'h5);
    for (int c = 0; c < 100 && model_rdy; c++) @(negedge clk);
    for (int c = 0; c < 100 && !model_rdy; c++) @(negedge clk);
    repeat (20) @(negedge clk);
    check("s5_scanning", 32'(rdy), 32'd0);
    rst_n = 1'b0;
    #1;
    check("s5_rst_rdy", 32'(rdy), 32'd1);
    check("s5_rst_key", 32'(key), 32'd0);
    check("s5_rst_key_valid", 32'(key_valid), 32'd0);
    check("s5_rst_a4_en", 32'(a4_en), 32'd0);
    check("s5_rst_a4_key", 32'(a4_key), 32'd0);
    check("s5_rst_chk_addr", 32'(chk_addr), 32'd0);
    base = pulses;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (60) @(negedge clk);
    check("s5_no_pulse", 32'(pulses - base), 32'd0);
    check("s5_idle_rdy", 32'(rdy), 32'd1);

    // Scenario 6: arc4 not ready before the first start.
    scen = 6;
    hold_busy = 1'b1;
    base = pulses;
    pulse_en();
    repeat (10) @(negedge clk);
    check("s6_held_a4_en", 32'(a4_en), 32'd0);
    check("s6_held_pulses", 32'(pulses - base), 32'd0);
    hold_busy = 1'b0;
    wait_done(300);
    check("s6_pulses", 32'(pulses - base), 32'd1);
    check("s6_key", 32'(key), 32'd0);
    check("s6_key_valid", 32'(key_valid), 32'd1);
    check("a4_en_single_cycle", 32'(dbl), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
